// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad one row at a time, debounces a single pressed
//   key, and reports it once per press.
//
//   Ports
//     clk          system clock, all logic on its rising edge
//     rst          asynchronous active-low reset (deassertion synchronized)
//     enable       scanning allowed while high
//     col_matriz   keypad columns, active-low, asynchronous to clk
//     lin_matriz   keypad row drive, active-low, at most one bit low
//     key_code     code of the last accepted key, held until the next one
//     key_valid    one-cycle pulse in the cycle key_code takes a new value
//     key_held     high while the accepted key remains pressed
//     dbg_state_o  current FSM state (encoding of state_t)
//
//   Output protocol: key_valid/key_code form a valid-only stream with no
//   back-pressure. key_code is stable whenever key_valid is high, key_valid
//   is never high on two consecutive cycles, and a held key produces one
//   pulse only (no auto-repeat).
module keypad_scanner #(
  parameter int SCAN_TICKS      = 4,   // cycles each row is driven, 3..255
  parameter int DEBOUNCE_CYCLES = 20   // stable samples for press/release, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] col_matriz,
  output logic [3:0] lin_matriz,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    DEBOUNCE = 3'd2,
    HELD     = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(SCAN_TICKS - 1);
  localparam logic [7:0] DEB_MAX   = 8'(DEBOUNCE_CYCLES);

  // Reset: asserts immediately, releases two clock edges after rst rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  // Column synchronizer, preset to "no key" so reset never looks like a press.
  logic [3:0] col_s1_q, col_s2_q;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_matriz;
      col_s2_q <= col_s1_q;
    end
  end

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [7:0] tick_q, tick_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      tick_q  <= 8'd0;
      cnt_q   <= 8'd0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Exactly one column low -> its index; anything else is "no single key".
  logic       one_low;
  logic [1:0] low_idx;

  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (col_s2_q)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Column pattern the latched key produces while its row is driven.
  logic [3:0] key_pat;
  assign key_pat = ~(4'b0001 << col_q);

  // Saturating increment of the shared debounce/release counter.
  logic [7:0] cnt_inc;
  assign cnt_inc = (cnt_q < DEB_MAX) ? cnt_q + 8'd1 : cnt_q;

  logic [3:0] map_code;

  always_comb begin
    map_code = 4'h0;
    case ({row_q, col_q})
      4'h0: map_code = 4'h1;
      4'h1: map_code = 4'h2;
      4'h2: map_code = 4'h3;
      4'h3: map_code = 4'hA;
      4'h4: map_code = 4'h4;
      4'h5: map_code = 4'h5;
      4'h6: map_code = 4'h6;
      4'h7: map_code = 4'hB;
      4'h8: map_code = 4'h7;
      4'h9: map_code = 4'h8;
      4'hA: map_code = 4'h9;
      4'hB: map_code = 4'hC;
      4'hC: map_code = 4'hE;
      4'hD: map_code = 4'h0;
      4'hE: map_code = 4'hF;
      4'hF: map_code = 4'hD;
      default: map_code = 4'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;

    if (!enable) begin
      // Abort whatever is in progress; key_code is deliberately kept.
      state_d = IDLE;
      row_d   = 2'd0;
      tick_d  = 8'd0;
      cnt_d   = 8'd0;
      held_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
          row_d   = 2'd0;
          tick_d  = 8'd0;
        end

        SCAN: begin
          // Columns are only trusted on the last cycle of the row window,
          // after the synchronizer has flushed the previous row's response.
          if (tick_q < TICK_LAST) begin
            tick_d = tick_q + 8'd1;
          end else begin
            tick_d = 8'd0;
            if (one_low) begin
              state_d = DEBOUNCE;
              col_d   = low_idx;
              cnt_d   = 8'd0;
            end else begin
              row_d = row_q + 2'd1;
            end
          end
        end

        DEBOUNCE: begin
          if (col_s2_q == key_pat) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_MAX) begin
              state_d = HELD;
              code_d  = map_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end else begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
            tick_d  = 8'd0;
          end
        end

        HELD: begin
          if (col_s2_q == 4'hF) begin
            state_d = RELEASE;
            cnt_d   = 8'd0;
          end
        end

        RELEASE: begin
          if (col_s2_q == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_MAX) begin
              state_d = SCAN;
              held_d  = 1'b0;
              row_d   = row_q + 2'd1;
              tick_d  = 8'd0;
            end
          end else begin
            // Release glitch: back to HELD, no new key_valid.
            state_d = HELD;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign lin_matriz  = (state_q == IDLE) ? 4'hF : ~(4'b0001 << row_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner: a behavioural 4x4 keypad closes the
//   loop from lin_matriz to col_matriz; every expected value is hand-derived.
module tb_keypad_scanner;

  localparam int SCAN_TICKS = 4;
  localparam int DEB        = 20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SCAN = 3'd1;
  localparam logic [2:0] ST_DEB  = 3'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] col_matriz;
  logic [3:0] lin_matriz;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_TICKS      (SCAN_TICKS),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .col_matriz  (col_matriz),
    .lin_matriz  (lin_matriz),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .dbg_state_o (dbg_state)
  );

  // ---------------- keypad model ----------------
  // pressed[row*4+col]; bounce_open forces all contacts open.
  logic [15:0] pressed = 16'h0;
  logic        bounce_open = 1'b0;

  always_comb begin
    col_matriz = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!lin_matriz[r] && pressed[r*4+c] && !bounce_open) col_matriz[c] = 1'b0;
  end

  // ---------------- monitor / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int kv_count = 0;
  int kv_cyc = 0;
  int kv_consec = 0;
  int deb_cycles = 0;
  logic [3:0] kv_code = 4'h0;
  logic prev_kv = 1'b0;
  logic [3:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_count++;
      kv_code = key_code;
      kv_cyc  = cyc;
      if (prev_kv) kv_consec++;
    end
    if (dbg_state == ST_DEB) deb_cycles++;
    prev_kv = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Waits for a fresh entry into row pattern pat (first cycle of the window).
  task automatic wait_lin(input string tag, input logic [3:0] pat, input int budget);
    int n = 0;
    while (lin_matriz === pat && n < budget) begin step(1); n++; end
    n = 0;
    while (lin_matriz !== pat && n < budget) begin step(1); n++; end
    check(tag, 32'(lin_matriz), 32'(pat));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (dbg_state !== s && n < budget) begin step(1); n++; end
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic wait_kv(input string tag, input int budget);
    int n = 0;
    int snap;
    snap = kv_count;
    while (kv_count == snap && n < budget) begin step(1); n++; end
    check(tag, 32'(kv_count - snap), 32'd1);
  endtask

  task automatic wait_unheld(input string tag, input int budget);
    int n = 0;
    while (key_held !== 1'b0 && n < budget) begin step(1); n++; end
    check(tag, 32'(key_held), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int kv0;
    int t_r1;
    int stable_cyc;
    int d0;
    logic [3:0] e;

    #2 rst = 1'b0;
    step(3);
    check("rst_lin", 32'(lin_matriz), 32'hF);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Release reset with enable already high: no scan within two edges.
    rst = 1'b1;
    enable = 1'b1;
    step(1);
    check("rel_edge1_lin", 32'(lin_matriz), 32'hF);
    step(1);
    check("rel_edge2_lin", 32'(lin_matriz), 32'hF);

    // Row order with no key: 4 cycles per row, row0..row3, wrap.
    wait_lin("row0_start", 4'b1110, 10);
    for (int i = 0; i <= 16; i++) begin
      e = ~(4'b0001 << ((i / 4) % 4));
      check($sformatf("row_order_%0d", i), 32'(lin_matriz), 32'(e));
      step(1);
    end

    // A: key "5" held 100 cycles.
    exp_q.push_back(4'h5);
    wait_lin("a_row3", 4'b0111, 40);
    pressed = 16'h0020;
    kv0 = kv_count;
    wait_lin("a_row1", 4'b1101, 40);
    t_r1 = cyc;
    step(96);
    check("a_kv_count", 32'(kv_count - kv0), 32'd1);
    check("a_kv_code", 32'(kv_code), 32'(exp_q.pop_front()));
    check("a_latency", 32'(kv_cyc - t_r1 - SCAN_TICKS), 32'd20);
    check("a_held", 32'(key_held), 32'd1);
    pressed = 16'h0;
    step(20);
    check("a_held_rel20", 32'(key_held), 32'd1);
    step(5);
    check("a_held_rel25", 32'(key_held), 32'd0);
    check("a_state_scan", 32'(dbg_state), 32'(ST_SCAN));

    // B: "#" bouncing every 3 cycles for 15 cycles, then stable.
    exp_q.push_back(4'hF);
    wait_lin("b_row2", 4'b1011, 40);
    kv0 = kv_count;
    pressed = 16'h4000;
    for (int i = 0; i < 15; i++) begin
      bounce_open = ((i / 3) % 2) == 1;
      step(1);
    end
    bounce_open = 1'b0;
    check("b_no_kv_bounce", 32'(kv_count - kv0), 32'd0);
    stable_cyc = cyc;
    step(60);
    check("b_kv_count", 32'(kv_count - kv0), 32'd1);
    check("b_kv_code", 32'(kv_code), 32'(exp_q.pop_front()));
    check("b_after_stable20", 32'((kv_cyc - stable_cyc) >= DEB), 32'd1);
    pressed = 16'h0;
    wait_unheld("b_unheld", 40);

    // C: "1" and "2" together on row0: ignored, scanning continues.
    wait_lin("c_row3", 4'b0111, 40);
    pressed = 16'h0003;
    kv0 = kv_count;
    d0 = deb_cycles;
    wait_lin("c_row1", 4'b1101, 20);
    wait_lin("c_row2", 4'b1011, 8);
    wait_lin("c_row3b", 4'b0111, 8);
    wait_lin("c_wrap_row0", 4'b1110, 8);
    check("c_no_kv", 32'(kv_count - kv0), 32'd0);
    check("c_no_debounce", 32'(deb_cycles - d0), 32'd0);
    pressed = 16'h0;
    step(4);

    // D: "9", enable dropped at debounce count 10.
    exp_q.push_back(4'h9);
    wait_lin("d_row1", 4'b1101, 40);
    pressed = 16'h0400;
    wait_state("d_debounce", ST_DEB, 20);
    kv0 = kv_count;
    step(10);
    enable = 1'b0;
    step(1);
    check("d_lin_idle", 32'(lin_matriz), 32'hF);
    check("d_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("d_no_kv_abort", 32'(kv_count - kv0), 32'd0);
    step(5);
    enable = 1'b1;
    wait_kv("d_kv", 80);
    check("d_kv_code", 32'(kv_code), 32'(exp_q.pop_front()));
    step(5);
    check("d_held", 32'(key_held), 32'd1);
    enable = 1'b0;
    step(1);
    check("d_dis_held", 32'(key_held), 32'd0);
    check("d_dis_code", 32'(key_code), 32'h9);
    pressed = 16'h0;
    step(3);
    enable = 1'b1;
    step(30);
    check("d_kv_total", 32'(kv_count - kv0), 32'd1);

    // E: "D", release glitch inside hold, then full release and re-press.
    exp_q.push_back(4'hD);
    exp_q.push_back(4'hD);
    pressed = 16'h8000;
    kv0 = kv_count;
    wait_kv("e_kv", 80);
    check("e_kv_code", 32'(kv_code), 32'(exp_q.pop_front()));
    step(5);
    pressed = 16'h0;
    step(5);
    pressed = 16'h8000;
    step(40);
    check("e_glitch_no_kv", 32'(kv_count - kv0), 32'd1);
    check("e_glitch_held", 32'(key_held), 32'd1);
    pressed = 16'h0;
    step(30);
    check("e_released", 32'(key_held), 32'd0);
    pressed = 16'h8000;
    wait_kv("e_kv2", 80);
    check("e_kv2_count", 32'(kv_count - kv0), 32'd2);
    check("e_kv2_code", 32'(kv_code), 32'(exp_q.pop_front()));
    pressed = 16'h0;
    wait_unheld("e_unheld", 40);

    // F: reset pulsed while "5" is held.
    exp_q.push_back(4'h5);
    pressed = 16'h0020;
    wait_kv("f_kv", 80);
    step(3);
    rst = 1'b0;
    #1;
    check("f_rst_lin", 32'(lin_matriz), 32'hF);
    check("f_rst_code", 32'(key_code), 32'h0);
    check("f_rst_valid", 32'(key_valid), 32'd0);
    check("f_rst_held", 32'(key_held), 32'd0);
    step(4);
    check("f_rst_held_hold", 32'(key_held), 32'd0);
    check("f_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    kv0 = kv_count;
    rst = 1'b1;
    wait_kv("f_kv_again", 80);
    check("f_kv_code", 32'(kv_code), 32'(exp_q.pop_front()));
    step(20);
    check("f_kv_once", 32'(kv_count - kv0), 32'd1);
    pressed = 16'h0;
    wait_unheld("f_unheld", 40);

    check("kv_never_consecutive", 32'(kv_consec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
